// File: rtl/adc_ad4003_ctrl.sv
// AD4003 conversion/readout controller: CNV pulse, SCK burst gate, deserializer
// shift window, delayed data_valid and a completed-sample counter.
module adc_ad4003_ctrl #(
    parameter int ADC_DATA_WIDTH   = 18,
    parameter int CNV_HIGH_CYCLES  = 4,
    parameter int CONV_WAIT_CYCLES = 24,
    parameter int FRAME_CYCLES     = 80,
    parameter int READ_LAT         = 4,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 adc_spi_clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 sync_in,
    output logic                 adc_cnv,
    output logic                 sck_en,
    output logic                 reader_en,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 sync_lost,
    output logic [CNT_WIDTH-1:0] sample_cnt
);

    localparam int FC_WIDTH = $clog2(FRAME_CYCLES);
    localparam logic [FC_WIDTH-1:0] CNV_LAST   = FC_WIDTH'(CNV_HIGH_CYCLES - 1);
    localparam logic [FC_WIDTH-1:0] WAIT_LAST  = FC_WIDTH'(CNV_HIGH_CYCLES + CONV_WAIT_CYCLES - 1);
    localparam logic [FC_WIDTH-1:0] SHIFT_LAST =
        FC_WIDTH'(CNV_HIGH_CYCLES + CONV_WAIT_CYCLES + ADC_DATA_WIDTH - 1);
    localparam logic [FC_WIDTH-1:0] FRAME_LAST = FC_WIDTH'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;
    logic                en_q;
    logic                cnv_d, shift_d, busy_d;
    logic                start;
    logic                reader_en_q;
    logic                reader_fall;
    logic [READ_LAT-1:0] dv_sr;

    // The FSM sees enable through one register, so a frame starts on the second
    // edge after enable is first sampled high.
    // NOTE: sequential state uses non-blocking assignments and an async reset so
    // every flop updates from pre-edge values and clears without a clock.
    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            fc_q    <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            en_q    <= enable;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                fc_d = '0;
                if (en_q) state_d = S_CNV;
            end
            S_CNV:   if (fc_q == CNV_LAST)   state_d = S_WAIT;
            S_WAIT:  if (fc_q == WAIT_LAST)  state_d = S_SHIFT;
            S_SHIFT: if (fc_q == SHIFT_LAST) state_d = S_GAP;
            S_GAP: begin
                if (fc_q == FRAME_LAST || sync_in) begin
                    fc_d    = '0;
                    state_d = en_q ? S_CNV : S_IDLE;
                end
            end
            default: begin
                fc_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one is a
    // flop that tracks the state register exactly.
    always_comb begin
        cnv_d   = (state_d == S_CNV);
        shift_d = (state_d == S_SHIFT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            adc_cnv   <= 1'b0;
            sck_en    <= 1'b0;
            reader_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            adc_cnv   <= cnv_d;
            sck_en    <= shift_d;
            reader_en <= shift_d;
            busy      <= busy_d;
        end
    end

    assign start = (state_q == S_IDLE) && (state_d == S_CNV);

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            sync_lost <= 1'b0;
        end else if (!enable) begin
            sync_lost <= 1'b0;
        end else if (sync_in && (state_q inside {S_CNV, S_WAIT, S_SHIFT})) begin
            sync_lost <= 1'b1;
        end
    end

    // The valid pulse follows reader_en alone, so a frame cut short by sync_in
    // or by dropping to IDLE still delivers its pending sample.
    assign reader_fall = reader_en_q & ~reader_en;

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            reader_en_q <= 1'b0;
            dv_sr       <= '0;
        end else begin
            reader_en_q <= reader_en;
            dv_sr       <= (dv_sr << 1) | READ_LAT'(reader_fall);
        end
    end

    assign data_valid = dv_sr[READ_LAT-1];

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            sample_cnt <= '0;
        end else if (start) begin
            sample_cnt <= '0;
        end else if (data_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_ad4003_ctrl.sv
// Bench for adc_ad4003_ctrl: directed frame-timing vectors plus randomized
// enable/sync/reset traffic compared every cycle against a frame-level model.
module tb_adc_ad4003_ctrl;

    localparam int CH = 4;
    localparam int CW = 24;
    localparam int W  = 18;
    localparam int F  = 80;
    localparam int RL = 4;
    localparam int SH_LO = CH + CW;
    localparam int SH_HI = CH + CW + W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b0;
    logic sync_in = 1'b0;

    logic adc_cnv, sck_en, reader_en, data_valid, busy, sync_lost;
    logic [31:0] sample_cnt;
    logic cnv4, sck4, rd4, dv4, busy4, lost4;
    logic [3:0] cnt4;

    int n_checks = 0;
    int n_errors = 0;
    bit mdl_on = 1'b0;

    always #5 clk = ~clk;

    adc_ad4003_ctrl dut (
        .adc_spi_clk(clk), .rstn(rstn), .enable(enable), .sync_in(sync_in),
        .adc_cnv(adc_cnv), .sck_en(sck_en), .reader_en(reader_en),
        .data_valid(data_valid), .busy(busy), .sync_lost(sync_lost),
        .sample_cnt(sample_cnt)
    );

    adc_ad4003_ctrl #(.CNT_WIDTH(4)) dut4 (
        .adc_spi_clk(clk), .rstn(rstn), .enable(enable), .sync_in(sync_in),
        .adc_cnv(cnv4), .sck_en(sck4), .reader_en(rd4),
        .data_valid(dv4), .busy(busy4), .sync_lost(lost4),
        .sample_cnt(cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a running flag, a position within the frame, and a
    // queue of cycle numbers at which a sample is due.
    bit        m_run, m_enq, m_lost, m_prev_sh, m_dv;
    int        m_fc, m_cyc;
    bit [31:0] m_cnt;
    int        dv_due[$];

    function automatic bit m_shift();
        return m_run && m_fc >= SH_LO && m_fc < SH_HI;
    endfunction

    function automatic logic [5:0] m_ctl();
        return {m_run && m_fc < CH, m_shift(), m_shift(), m_dv, m_run, m_lost};
    endfunction

    task automatic model_step();
        bit gap, sh;
        if (!rstn) begin
            m_run = 0; m_enq = 0; m_lost = 0; m_prev_sh = 0; m_dv = 0;
            m_fc = 0; m_cyc = 0; m_cnt = '0;
            dv_due.delete();
        end else begin
            m_cyc++;
            gap = m_run && m_fc >= SH_HI;
            if (!enable) m_lost = 0;
            else if (sync_in && m_run && !gap) m_lost = 1;
            if (m_dv) m_cnt++;
            if (!m_run) begin
                if (m_enq) begin
                    m_run = 1; m_fc = 0; m_cnt = '0;
                end
            end else if (m_fc == F - 1 || (gap && sync_in)) begin
                m_run = m_enq; m_fc = 0;
            end else begin
                m_fc++;
            end
            m_enq = enable;
            sh = m_shift();
            if (m_prev_sh && !sh) dv_due.push_back(m_cyc + RL);
            m_prev_sh = sh;
            m_dv = 0;
            if (dv_due.size() > 0 && dv_due[0] == m_cyc) begin
                m_dv = 1;
                void'(dv_due.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            check("mdl_ctl", 64'({adc_cnv, sck_en, reader_en, data_valid, busy, sync_lost}), 64'(m_ctl()));
            check("mdl_cnt", 64'(sample_cnt), 64'(m_cnt));
            check("mdl_ctl4", 64'({cnv4, sck4, rd4, dv4, busy4, lost4}), 64'(m_ctl()));
            check("mdl_cnt4", 64'(cnt4), 64'(m_cnt[3:0]));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed-sequence helpers; all stimulus changes and samples happen 2 ns
    // after the rising edge.
    int cur_fc, n_sck, n_dv, dv_fc;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic advance(input int target);
        while (cur_fc < target) begin
            step();
            cur_fc++;
            if (sck_en) n_sck++;
            if (data_valid) begin
                n_dv++;
                dv_fc = cur_fc;
            end
        end
    endtask

    task automatic start_frame(input string name);
        enable = 1'b1;
        step();
        check({name, "_startup_lat"}, 64'(adc_cnv), 64'(0));
        step();
        check({name, "_cnv_rise"}, 64'(adc_cnv), 64'(1));
        cur_fc = 0; n_sck = 0; n_dv = 0; dv_fc = -1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'(0));
        step();
    endtask

    typedef struct {
        int         fc;
        logic [2:0] ctl;  // {adc_cnv, sck_en, data_valid}
        int         cnt;  // -1: not compared
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int fc, input logic [2:0] ctl, input int cnt);
        vec_t v;
        v.fc = fc; v.ctl = ctl; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        add(0,   3'b100, 0);  add(3,   3'b100, -1); add(4,   3'b000, -1);
        add(27,  3'b000, -1); add(28,  3'b010, -1); add(45,  3'b010, -1);
        add(46,  3'b000, -1); add(49,  3'b000, 0);  add(50,  3'b001, 0);
        add(51,  3'b000, 1);  add(79,  3'b000, 1);  add(80,  3'b100, 1);
        add(83,  3'b100, -1); add(84,  3'b000, -1); add(108, 3'b010, -1);
        add(130, 3'b001, 1);  add(131, 3'b000, 2);  add(160, 3'b100, -1);
        add(163, 3'b100, -1); add(164, 3'b000, -1); add(210, 3'b001, 2);
        add(211, 3'b000, 3);

        // Reset state, then idle after release.
        step(); step();
        check("reset_ctl", 64'({adc_cnv, sck_en, reader_en, data_valid, busy, sync_lost}), 64'(0));
        check("reset_cnt", 64'(sample_cnt), 64'(0));
        rstn = 1'b1;
        mdl_on = 1'b1;
        step();
        check("idle_ctl", 64'({adc_cnv, sck_en, reader_en, data_valid, busy, sync_lost}), 64'(0));

        // Three consecutive frames against the vector table.
        start_frame("a");
        foreach (tbl[i]) begin
            advance(tbl[i].fc);
            check($sformatf("tbl_fc%0d", tbl[i].fc), 64'({adc_cnv, sck_en, data_valid}), 64'(tbl[i].ctl));
            if (tbl[i].cnt >= 0)
                check($sformatf("tbl_cnt_fc%0d", tbl[i].fc), 64'(sample_cnt), 64'(tbl[i].cnt));
        end
        check("a_sck_total", 64'(n_sck), 64'(3 * W));
        check("a_dv_total", 64'(n_dv), 64'(3));
        enable = 1'b0;
        wait_idle("a");

        // Enable dropped mid-frame: the frame still completes.
        start_frame("b");
        advance(10);
        enable = 1'b0;
        advance(80);
        check("b_sck_count", 64'(n_sck), 64'(W));
        check("b_dv_fc", 64'(dv_fc), 64'(50));
        check("b_busy_fc80", 64'({busy, adc_cnv}), 64'(0));
        wait_idle("b");

        // sync_in in GAP restarts the frame early.
        start_frame("c");
        advance(60);
        sync_in = 1'b1;
        advance(61);
        sync_in = 1'b0;
        check("c_cnv_fc61", 64'(adc_cnv), 64'(1));
        check("c_sync_lost", 64'(sync_lost), 64'(0));
        enable = 1'b0;
        wait_idle("c");

        // sync_in in SHIFT is ignored but flagged; flag clears with enable low.
        start_frame("d");
        advance(30);
        sync_in = 1'b1;
        advance(31);
        sync_in = 1'b0;
        check("d_sync_lost_set", 64'(sync_lost), 64'(1));
        check("d_sck_fc31", 64'(sck_en), 64'(1));
        advance(80);
        check("d_sck_count", 64'(n_sck), 64'(W));
        check("d_dv_fc", 64'(dv_fc), 64'(50));
        check("d_cnv_fc80", 64'(adc_cnv), 64'(1));
        check("d_sync_lost_held", 64'(sync_lost), 64'(1));
        enable = 1'b0;
        step();
        check("d_sync_lost_clr", 64'(sync_lost), 64'(0));
        wait_idle("d");

        // Reset mid-frame: outputs drop at once, pending sample discarded.
        start_frame("e");
        advance(F + 35);
        check("e_cnt_pre", 64'(sample_cnt), 64'(1));
        rstn = 1'b0;
        #1;
        check("e_rst_ctl", 64'({adc_cnv, sck_en, reader_en, data_valid, busy, sync_lost}), 64'(0));
        check("e_rst_cnt", 64'(sample_cnt), 64'(0));
        step(); step();
        rstn = 1'b1;
        step();
        check("e_restart_lat", 64'(adc_cnv), 64'(0));
        step();
        check("e_restart_cnv", 64'(adc_cnv), 64'(1));
        check("e_restart_cnt", 64'(sample_cnt), 64'(0));
        cur_fc = 0; n_sck = 0; n_dv = 0; dv_fc = -1;
        advance(49);
        check("e_no_stale_dv", 64'(n_dv), 64'(0));
        advance(51);
        check("e_dv_fc", 64'(dv_fc), 64'(50));
        check("e_cnt_fc51", 64'(sample_cnt), 64'(1));
        enable = 1'b0;
        wait_idle("e");

        // Narrow counter wraps after 15, then clears on re-enable.
        start_frame("f");
        for (int j = 1; j <= 17; j++) begin
            advance(F * (j - 1) + 51);
            check($sformatf("f_cnt4_frame%0d", j), 64'(cnt4), 64'(j % 16));
            check($sformatf("f_cnt32_frame%0d", j), 64'(sample_cnt), 64'(j));
        end
        enable = 1'b0;
        wait_idle("f");
        check("f_cnt4_held", 64'(cnt4), 64'(1));
        start_frame("g");
        check("g_cnt4_clr", 64'(cnt4), 64'(0));
        advance(51);
        check("g_cnt4_first", 64'(cnt4), 64'(1));
        enable = 1'b0;
        wait_idle("g");

        // Randomized enable / sync_in / reset traffic, checked by the model.
        for (int i = 0; i < 6000; i++) begin
            step();
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            sync_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end
        end
        sync_in = 1'b0;
        enable = 1'b0;
        wait_idle("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
